// File: rtl/sr_xfer_ctrl.sv
// Serial exchange sequencer for an 8-bit universal shift register: load a word,
// shift len bits out/in paced by bit_tick, then return the captured word.
module sr_xfer_ctrl #(
    parameter  int WIDTH = 8,
    localparam int LEN_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_abort,
    input  logic             bit_tick,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic [1:0]       sr_ctrl,
    output logic [WIDTH-1:0] sr_par_in,
    input  logic [WIDTH-1:0] sr_par_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_e;

    localparam logic [1:0] CTRL_HOLD  = 2'd0;
    localparam logic [1:0] CTRL_LEFT  = 2'd1;
    localparam logic [1:0] CTRL_RIGHT = 2'd2;
    localparam logic [1:0] CTRL_LOAD  = 2'd3;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   par_in_q, par_in_d;
    logic [LEN_W-1:0]   eff_len;

    // A zero or oversized length means a full-word exchange.
    assign eff_len = ((cmd_len == '0) || (cmd_len > LEN_W'(WIDTH))) ? LEN_W'(WIDTH) : cmd_len;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            dir_q     <= 1'b0;
            par_in_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            dir_q     <= dir_d;
            par_in_q  <= par_in_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        dir_d     = dir_q;
        par_in_d  = par_in_q;
        sr_ctrl   = CTRL_HOLD;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    par_in_d  = cmd_data;
                    dir_d     = cmd_dir;
                    bit_cnt_d = eff_len;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cmd_abort) begin
                    state_d = ST_IDLE;
                end else begin
                    sr_ctrl = CTRL_LOAD;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cmd_abort) begin
                    state_d = ST_IDLE;
                end else if (bit_tick) begin
                    sr_ctrl = dir_q ? CTRL_RIGHT : CTRL_LEFT;
                    if (bit_cnt_q != '0) begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                    // The <= guard keeps a corrupted zero count from stranding the FSM.
                    if (bit_cnt_q <= LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (cmd_abort || rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    // The shifter holds while in DONE, so passing par_out through is stable.
    assign rsp_data  = (state_q == ST_DONE) ? sr_par_out : '0;
    assign sr_par_in = par_in_q;

endmodule

// File: tb/tb_sr_xfer_ctrl.sv
// Directed self-checking bench for sr_xfer_ctrl with a behavioural shift register
// attached to sr_ctrl/sr_par_in/sr_par_out.
module tb_sr_xfer_ctrl;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_dir;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_abort;
    logic             bit_tick;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;
    logic [1:0]       sr_ctrl;
    logic [WIDTH-1:0] sr_par_in;
    logic [WIDTH-1:0] sr_par_out;

    logic             ser_in;
    logic             ser_out;
    logic [WIDTH-1:0] sr_q = '0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sr_xfer_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_dir   (cmd_dir),
        .cmd_len   (cmd_len),
        .cmd_abort (cmd_abort),
        .bit_tick  (bit_tick),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .sr_ctrl   (sr_ctrl),
        .sr_par_in (sr_par_in),
        .sr_par_out(sr_par_out)
    );

    // Behavioural universal shift register driven by the controller.
    always @(posedge clk) begin
        case (sr_ctrl)
            2'd1:    sr_q <= {sr_q[WIDTH-2:0], ser_in};
            2'd2:    sr_q <= {ser_in, sr_q[WIDTH-1:1]};
            2'd3:    sr_q <= sr_par_in;
            default: sr_q <= sr_q;
        endcase
    end
    assign sr_par_out = sr_q;
    assign ser_out    = (sr_ctrl == 2'd2) ? sr_q[0] : sr_q[WIDTH-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] t1_in;
        logic [7:0] t1_out;
        logic [7:0] t2_out;
        logic [7:0] t5_in;
        int         nz;
        logic       saw_valid;

        t1_in  = 8'b1011_0010;
        t1_out = 8'b1001_1000;
        t2_out = 8'b0000_0101;
        t5_in  = 8'b1000_0001;

        rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_dir = 1'b0; cmd_len = '0;
        cmd_abort = 1'b0; bit_tick = 1'b0; rsp_ready = 1'b0; ser_in = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_sr_ctrl", sr_ctrl, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_sr_par_in", sr_par_in, 0);

        // MSB-first full word
        cmd_valid = 1'b1; cmd_data = 8'h98; cmd_dir = 1'b0; cmd_len = 4'd8; bit_tick = 1'b1;
        #1;
        check("t1_accept_ready", cmd_ready, 1);
        check("t1_accept_ctrl", sr_ctrl, 0);
        cycle();
        cmd_valid = 1'b0;
        #1;
        check("t1_load_ctrl", sr_ctrl, 3);
        check("t1_load_par_in", sr_par_in, 8'h98);
        check("t1_load_busy", busy, 1);
        check("t1_load_ready", cmd_ready, 0);
        cycle();
        for (int i = 0; i < 8; i++) begin
            ser_in = t1_in[7-i];
            #1;
            check("t1_shift_ctrl", sr_ctrl, 1);
            check("t1_ser_out", ser_out, t1_out[7-i]);
            check("t1_no_rsp", rsp_valid, 0);
            cycle();
        end
        #1;
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_data", rsp_data, 8'hB2);
        check("t1_done_ctrl", sr_ctrl, 0);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        #1;
        check("t1_idle_ready", cmd_ready, 1);
        check("t1_idle_rsp", rsp_valid, 0);

        // LSB-first partial
        cmd_valid = 1'b1; cmd_data = 8'hA5; cmd_dir = 1'b1; cmd_len = 4'd4; ser_in = 1'b1;
        #1;
        cycle();
        cmd_valid = 1'b0;
        #1;
        check("t2_load_ctrl", sr_ctrl, 3);
        cycle();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_shift_ctrl", sr_ctrl, 2);
            check("t2_ser_out", ser_out, t2_out[i]);
            check("t2_no_rsp", rsp_valid, 0);
            cycle();
        end
        #1;
        check("t2_done_ctrl", sr_ctrl, 0);
        check("t2_rsp_valid", rsp_valid, 1);
        check("t2_rsp_data", rsp_data, 8'hFA);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;

        // Gapped ticks, len=0 means full word
        cmd_valid = 1'b1; cmd_data = 8'h3C; cmd_dir = 1'b0; cmd_len = 4'd0; bit_tick = 1'b0; ser_in = 1'b1;
        #1;
        cycle();
        cmd_valid = 1'b0;
        #1;
        check("t3_load_ctrl", sr_ctrl, 3);
        cycle();
        nz = 0;
        for (int k = 0; k < 22; k++) begin
            bit_tick = (k % 3 == 0);
            #1;
            check("t3_gap_ctrl", sr_ctrl, (k % 3 == 0) ? 1 : 0);
            check("t3_busy", busy, 1);
            check("t3_no_rsp", rsp_valid, 0);
            if (sr_ctrl != 2'd0) nz++;
            cycle();
        end
        check("t3_shift_count", nz, 8);

        // Backpressure in DONE
        bit_tick = 1'b1; rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t4_bp_valid", rsp_valid, 1);
            check("t4_bp_data", rsp_data, 8'hFF);
            check("t4_bp_ready", cmd_ready, 0);
            check("t4_bp_ctrl", sr_ctrl, 0);
            cycle();
        end
        rsp_ready = 1'b1;
        #1;
        check("t4_hs_valid", rsp_valid, 1);
        cycle();
        rsp_ready = 1'b0;
        #1;
        check("t4_idle_ready", cmd_ready, 1);
        check("t4_idle_busy", busy, 0);

        // Abort after 3 shifts
        cmd_valid = 1'b1; cmd_data = 8'h5A; cmd_dir = 1'b0; cmd_len = 4'd8; ser_in = 1'b0;
        #1;
        cycle();
        cmd_valid = 1'b0;
        cycle();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_shift_ctrl", sr_ctrl, 1);
            cycle();
        end
        cmd_abort = 1'b1;
        #1;
        check("t5_abort_ctrl", sr_ctrl, 0);
        cycle();
        // Abort stays high in IDLE and must not block a new command.
        cmd_valid = 1'b1; cmd_data = 8'hC3; cmd_dir = 1'b1; cmd_len = 4'd9;
        #1;
        check("t5_idle_busy", busy, 0);
        check("t5_idle_ready", cmd_ready, 1);
        check("t5_idle_rsp", rsp_valid, 0);
        check("t5_idle_ctrl", sr_ctrl, 0);
        check("t5_sr_left_as_is", sr_par_out, 8'hD0);
        cycle();
        cmd_valid = 1'b0; cmd_abort = 1'b0;
        #1;
        check("t5_load_ctrl", sr_ctrl, 3);
        check("t5_load_par_in", sr_par_in, 8'hC3);
        cycle();
        for (int i = 0; i < 8; i++) begin
            ser_in = t5_in[7-i];
            #1;
            check("t5_shift2_ctrl", sr_ctrl, 2);
            check("t5_no_rsp", rsp_valid, 0);
            cycle();
        end
        #1;
        check("t5_rsp_valid", rsp_valid, 1);
        check("t5_rsp_data", rsp_data, 8'h81);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;

        // Asynchronous reset mid-SHIFT
        cmd_valid = 1'b1; cmd_data = 8'h77; cmd_dir = 1'b0; cmd_len = 4'd8; ser_in = 1'b0;
        #1;
        cycle();
        cmd_valid = 1'b0;
        cycle();
        cycle();
        cycle();
        #1;
        check("t6_shift_ctrl", sr_ctrl, 1);
        check("t6_busy_pre", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_ctrl", sr_ctrl, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_rsp", rsp_valid, 0);
        check("t6_rst_par_in", sr_par_in, 0);
        cycle();
        rst = 1'b0;
        #1;
        check("t6_rel_ready", cmd_ready, 1);
        check("t6_rel_rsp", rsp_valid, 0);
        check("t6_rel_data", rsp_data, 0);
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) saw_valid = 1'b1;
        end
        check("t6_no_response", saw_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr_xfer_ctrl.md
Name: sr_xfer_ctrl

Overview:
- Sequencer for the 8-bit universal shift_register, running serial exchanges: parallel-load a word, shift len bits out on ser_out while shifting len bits in from ser_in, then return the captured word.
- Sits between a command/response valid-ready interface and one shift_register instance.
- The shift rate is gated by an external bit tick (baud/clock-divider strobe).

Parameters:
- WIDTH, 8, shift register width in bits (matches shift_register par_in/par_out).
- LEN_W, $clog2(WIDTH)+1, width of the length field (localparam, derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_data  in  WIDTH  word to parallel-load.
- cmd_dir  in  1  0 = MSB-first (shift left), 1 = LSB-first (shift right).
- cmd_len  in  LEN_W  bits to shift. 0 or values above WIDTH mean WIDTH.
- cmd_abort  in  1  synchronous abort of the current exchange.
- bit_tick  in  1  one-cycle strobe enabling one shift.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted when rsp_valid & rsp_ready.
- rsp_data  out  WIDTH  captured word.
- busy  out  1  high in any state other than IDLE.
- sr_ctrl  out  2  drives shift_register ctrl: 0 hold, 1 shift left, 2 shift right, 3 parallel load.
- sr_par_in  out  WIDTH  drives shift_register par_in.
- sr_par_out  in  WIDTH  from shift_register par_out.

Behaviour:
- shift_register semantics this block relies on:
  - ctrl=1: ser_in enters bit0; ser_out = bit WIDTH-1.
  - ctrl=2: ser_in enters bit WIDTH-1; ser_out = bit0.
  - All ctrl actions take effect on the rising clk edge.
  - The ser_in/ser_out pins connect top-level to shift_register; this block does not touch them.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: cmd_ready=1, sr_ctrl=0.
  - On accept: register cmd_data into sr_par_in; latch dir; latch eff_len (cmd_len, or WIDTH if 0 or >WIDTH) into bit_cnt; next state LOAD.
- LOAD: exactly one cycle. sr_ctrl=3. Next state SHIFT. bit_tick is ignored here.
- SHIFT: sr_ctrl = (dir ? 2 : 1) when bit_tick=1, else 0.
  - Each tick cycle decrements bit_cnt.
  - A tick with bit_cnt==1 moves the FSM to DONE.
- DONE: sr_ctrl=0, rsp_valid=1, rsp_data = sr_par_out (the shifter holds, so the value is stable).
  - On rsp_ready: next state IDLE.
  - Hold rsp_valid and rsp_data stable under backpressure.
- sr_ctrl is combinational from state, dir and bit_tick. All other outputs are registered or decoded from state only.
- Latency with bit_tick held high:
  - Accept in cycle T; LOAD in T+1; shifts in T+2 .. T+1+eff_len.
  - rsp_valid first high in T+2+eff_len.
  - Next command can be accepted in the cycle after the response handshake (no IDLE bypass).
- cmd_abort: in LOAD, SHIFT or DONE, the next state is IDLE.
  - sr_ctrl=0 in the abort cycle (abort has priority over bit_tick and rsp_ready).
  - No response is produced; shift register contents are left as-is.
  - Ignored in IDLE; a cmd_valid in the same cycle is still accepted.
- cmd_valid/cmd_data are not sampled outside IDLE.
- rst, asynchronous:
  - state=IDLE, bit_cnt=0, dir=0, sr_par_in=0.
  - Outputs: cmd_ready=1 after release, rsp_valid=0, busy=0, sr_ctrl=0, rsp_data=0.
  - Reset mid-exchange discards the transaction.
- bit_cnt width is LEN_W and never wraps: decrement only when bit_cnt>0 in SHIFT.

Test Plan:
- MSB-first full word: cmd_data=0x98, dir=0, len=8, bit_tick=1, ser_in 1,0,1,1,0,0,1,0 -> ser_out 1,0,0,1,1,0,0,0; rsp_data=0xB2; rsp_valid in T+10.
- LSB-first partial: cmd_data=0xA5, dir=1, len=4, ser_in 1,1,1,1 -> ser_out 1,0,1,0; rsp_data=0xFA; exactly 4 cycles with sr_ctrl=2.
- Gapped ticks: bit_tick every 3rd cycle, len=0 -> sr_ctrl nonzero only on tick cycles; 8 shifts total; busy high throughout.
- Backpressure: rsp_ready low 5 cycles in DONE -> rsp_valid/rsp_data stable, cmd_ready=0, sr_ctrl=0; IDLE one cycle after handshake.
- Abort: cmd_abort after 3 shifts of an 8-bit exchange -> IDLE next cycle, rsp_valid never asserts, cmd_ready=1; a following command completes normally.
- Async rst asserted mid-SHIFT between clock edges -> sr_ctrl=0 and busy=0 immediately; no response; rsp_valid=0 after release.
